// File: rtl/pipe_defs_pkg.sv
// Shared pipeline definitions: register/data widths, opcode constants and the
// writeback queue entry type used by the write-port arbiter and its FIFO.
package pipe_defs_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_BRANCH = 6'b000100;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
    logic              kill;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of pending mul/div results. A kill request marks every stored
// entry with a matching rd so it retires without writing the register file.
module wb_result_fifo
  import pipe_defs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_rd,
  output wb_entry_t         head,
  output logic [CW-1:0]     count
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t         mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign pop_ok_s  = pop && (count_r != {CW{1'b0}});
  assign push_ok_s = push && ((count_r < CW'(DEPTH)) || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage: the push write is placed after the kill loop so a same-cycle
  // enqueue with a matching rd lands un-killed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (mem_r[i].rd == kill_rd)) begin
          mem_r[i].kill <= 1'b1;
        end
      end
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_entry;
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, mul/div results queue
// and drain in idle slots; a starved or full queue stalls the pipeline for one slot.
// Optional macro WB_BYPASS_EN: write a mul/div result directly when nothing else competes.
module wb_port_arbiter
  import pipe_defs_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int AW           = REG_AW,
  parameter int DW           = REG_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_regwrite_i,
  input  logic                     wb_memtoreg_i,
  input  logic [AW-1:0]            wb_rd_i,
  input  logic [DW-1:0]            wb_alu_i,
  input  logic [DW-1:0]            wb_mem_i,
  input  logic                     md_valid_i,
  output logic                     md_ready_o,
  input  logic [AW-1:0]            md_rd_i,
  input  logic [DW-1:0]            md_data_i,
  output logic                     rf_we_o,
  output logic [AW-1:0]            rf_waddr_o,
  output logic [DW-1:0]            rf_wdata_o,
  output logic                     stall_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int AGW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t      head_s;
  wb_entry_t      push_entry_s;
  logic [CW-1:0]  count_s;
  logic [AGW-1:0] age_r;
  logic [AGW-1:0] age_n_s;
  logic           stall_s;
  logic           md_fire_s;
  logic           md_drop_s;
  logic           push_s;
  logic           pop_s;
  logic           kill_en_s;
  logic           bypass_s;
  logic           we_n_s;
  logic [AW-1:0]  waddr_n_s;
  logic [DW-1:0]  wdata_n_s;

  assign stall_s    = (count_s != {CW{1'b0}}) &&
                      ((age_r >= AGW'(STARVE_LIMIT)) || (count_s == CW'(DEPTH)));
  assign stall_o    = stall_s;
  assign md_ready_o = (count_s < CW'(DEPTH));
  assign md_fire_s  = md_valid_i && md_ready_o;
  assign md_drop_s  = (md_rd_i == {AW{1'b0}});
  assign fifo_count_o = count_s;

  assign push_entry_s.rd   = md_rd_i;
  assign push_entry_s.data = md_data_i;
  assign push_entry_s.kill = 1'b0;

  // Grant mux: stall drain, then pipeline, then idle-slot drain, then optional bypass.
  always_comb begin
    pop_s     = 1'b0;
    kill_en_s = 1'b0;
    bypass_s  = 1'b0;
    we_n_s    = 1'b0;
    waddr_n_s = {AW{1'b0}};
    wdata_n_s = {DW{1'b0}};
    if (stall_s || (!(wb_regwrite_i && (wb_rd_i != {AW{1'b0}})) && (count_s != {CW{1'b0}}))) begin
      pop_s = 1'b1;
      if (head_s.kill) begin
        we_n_s = 1'b0;
      end else begin
        we_n_s    = 1'b1;
        waddr_n_s = head_s.rd;
        wdata_n_s = head_s.data;
      end
    end else if (wb_regwrite_i && (wb_rd_i != {AW{1'b0}})) begin
      kill_en_s = 1'b1;
      we_n_s    = 1'b1;
      waddr_n_s = wb_rd_i;
      wdata_n_s = wb_memtoreg_i ? wb_mem_i : wb_alu_i;
    end else begin
`ifdef WB_BYPASS_EN
      if (md_fire_s && !md_drop_s) begin
        bypass_s  = 1'b1;
        we_n_s    = 1'b1;
        waddr_n_s = md_rd_i;
        wdata_n_s = md_data_i;
      end else begin
        bypass_s  = 1'b0;
      end
`else
      bypass_s = 1'b0;
`endif
    end
    push_s = md_fire_s && !md_drop_s && !bypass_s;
  end

  // Head age: restarts on every pop so each new head gets its own wait budget.
  always_comb begin
    if ((count_s == {CW{1'b0}}) || pop_s) begin
      age_n_s = {AGW{1'b0}};
    end else if (age_r < AGW'(STARVE_LIMIT)) begin
      age_n_s = age_r + AGW'(1);
    end else begin
      age_n_s = age_r;
    end
  end

  // Age register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_r <= {AGW{1'b0}};
    end else begin
      age_r <= age_n_s;
    end
  end

  // Registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= {AW{1'b0}};
      rf_wdata_o <= {DW{1'b0}};
    end else begin
      rf_we_o    <= we_n_s;
      rf_waddr_o <= waddr_n_s;
      rf_wdata_o <= wdata_n_s;
    end
  end

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .kill_en    (kill_en_s),
    .kill_rd    (wb_rd_i),
    .head       (head_s),
    .count      (count_s)
  );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (honours WB_BYPASS_EN if defined).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_regwrite_i, wb_memtoreg_i;
  logic [4:0]  wb_rd_i, md_rd_i, rf_waddr_o;
  logic [31:0] wb_alu_i, wb_mem_i, md_data_i, rf_wdata_o;
  logic        md_valid_i, md_ready_o, rf_we_o, stall_o;
  logic [2:0]  fifo_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_regwrite_i(wb_regwrite_i), .wb_memtoreg_i(wb_memtoreg_i),
    .wb_rd_i(wb_rd_i), .wb_alu_i(wb_alu_i), .wb_mem_i(wb_mem_i),
    .md_valid_i(md_valid_i), .md_ready_o(md_ready_o),
    .md_rd_i(md_rd_i), .md_data_i(md_data_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .stall_o(stall_o), .fifo_count_o(fifo_count_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic rw, input logic [4:0] rd, input logic [31:0] alu);
    wb_regwrite_i = rw; wb_memtoreg_i = 1'b0; wb_rd_i = rd; wb_alu_i = alu;
  endtask

  task automatic md(input logic v, input logic [4:0] rd, input logic [31:0] d);
    md_valid_i = v; md_rd_i = rd; md_data_i = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pipe(1'b0, 5'd0, 32'd0); wb_mem_i = 32'd0; md(1'b0, 5'd0, 32'd0);
    step(); step();
    n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", rf_we_o); end
    n_checks++; if (rf_waddr_o !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got %0d want 0", rf_waddr_o); end
    n_checks++; if (rf_wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", rf_wdata_o); end
    n_checks++; if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall_o); end
    n_checks++; if (md_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", md_ready_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_pipeline();
    pipe(1'b1, 5'd5, 32'h1111_1111); wb_memtoreg_i = 1'b1; wb_mem_i = 32'hDEAD_BEEF;
    step();
    n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
      begin n_fail++; $display("FAIL pipe_mem got we=%0b a=%0d d=%h want 1/5/deadbeef", rf_we_o, rf_waddr_o, rf_wdata_o); end
    pipe(1'b1, 5'd6, 32'hCAFE_0001);
    step();
    n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd6, 32'hCAFE_0001})
      begin n_fail++; $display("FAIL pipe_alu got we=%0b a=%0d d=%h want 1/6/cafe0001", rf_we_o, rf_waddr_o, rf_wdata_o); end
    pipe(1'b1, 5'd0, 32'h0000_0099);
    step();
    n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL pipe_r0 got we=%0b want 0", rf_we_o); end
    pipe(1'b0, 5'd6, 32'h0000_0001);
    step();
    n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL pipe_idle got we=%0b want 0", rf_we_o); end
  endtask

  task automatic test_contention();
    pipe(1'b1, 5'd3, 32'h0000_000A);
    md(1'b1, 5'd7, 32'h0000_0012);
    step();
    md(1'b0, 5'd0, 32'd0);
    n_checks++; if ({fifo_count_o, rf_we_o, rf_waddr_o} !== {3'd1, 1'b1, 5'd3})
      begin n_fail++; $display("FAIL cont_push got cnt=%0d we=%0b a=%0d want 1/1/3", fifo_count_o, rf_we_o, rf_waddr_o); end
    for (int k = 1; k <= 7; k++) step();
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL cont_early got stall=%0b want 0", stall_o); end
    step();
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL cont_stall got stall=%0b want 1", stall_o); end
    step();
    n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'h0000_0012})
      begin n_fail++; $display("FAIL cont_drain got we=%0b a=%0d d=%h want 1/7/12", rf_we_o, rf_waddr_o, rf_wdata_o); end
    n_checks++; if ({stall_o, fifo_count_o} !== {1'b0, 3'd0})
      begin n_fail++; $display("FAIL cont_after got stall=%0b cnt=%0d want 0/0", stall_o, fifo_count_o); end
    pipe(1'b0, 5'd0, 32'd0);
    step();
  endtask

  task automatic test_full();
    pipe(1'b1, 5'd3, 32'h0000_000B);
    for (int i = 0; i < 4; i++) begin
      md(1'b1, 5'(10 + i), 32'(32'h100 + i));
      step();
    end
    md(1'b0, 5'd0, 32'd0);
    n_checks++; if ({fifo_count_o, md_ready_o, stall_o} !== {3'd4, 1'b0, 1'b1})
      begin n_fail++; $display("FAIL full_state got cnt=%0d rdy=%0b stall=%0b want 4/0/1", fifo_count_o, md_ready_o, stall_o); end
    step();
    n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd10, 32'h0000_0100})
      begin n_fail++; $display("FAIL full_drain got we=%0b a=%0d d=%h want 1/10/100", rf_we_o, rf_waddr_o, rf_wdata_o); end
    n_checks++; if ({fifo_count_o, md_ready_o, stall_o} !== {3'd3, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL full_after got cnt=%0d rdy=%0b stall=%0b want 3/1/0", fifo_count_o, md_ready_o, stall_o); end
    pipe(1'b0, 5'd0, 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'(10 + i), 32'(32'h100 + i)})
        begin n_fail++; $display("FAIL full_idle_drain%0d got we=%0b a=%0d d=%h", i, rf_we_o, rf_waddr_o, rf_wdata_o); end
    end
    n_checks++; if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL full_empty got cnt=%0d want 0", fifo_count_o); end
  endtask

  task automatic test_waw();
    pipe(1'b1, 5'd3, 32'h0000_0003);
    md(1'b1, 5'd9, 32'h0000_0001);
    step();
    md(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd9, 32'h0000_0002);
    step();
    n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, fifo_count_o} !== {1'b1, 5'd9, 32'h0000_0002, 3'd1})
      begin n_fail++; $display("FAIL waw_pipe got we=%0b a=%0d d=%h cnt=%0d want 1/9/2/1", rf_we_o, rf_waddr_o, rf_wdata_o, fifo_count_o); end
    pipe(1'b0, 5'd0, 32'd0);
    step();
    n_checks++; if ({rf_we_o, fifo_count_o} !== {1'b0, 3'd0})
      begin n_fail++; $display("FAIL waw_killed got we=%0b cnt=%0d want 0/0", rf_we_o, fifo_count_o); end
    pipe(1'b1, 5'd8, 32'h0000_0077);
    md(1'b1, 5'd8, 32'h0000_0008);
    step();
    md(1'b0, 5'd0, 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    step();
    n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd8, 32'h0000_0008})
      begin n_fail++; $display("FAIL waw_same_cycle got we=%0b a=%0d d=%h want 1/8/8", rf_we_o, rf_waddr_o, rf_wdata_o); end
  endtask

  task automatic test_md_r0();
    md(1'b1, 5'd0, 32'h0000_00AA);
    step();
    md(1'b0, 5'd0, 32'd0);
    n_checks++; if ({rf_we_o, fifo_count_o} !== {1'b0, 3'd0})
      begin n_fail++; $display("FAIL md_r0 got we=%0b cnt=%0d want 0/0", rf_we_o, fifo_count_o); end
  endtask

  task automatic test_bypass();
    md(1'b1, 5'd4, 32'h0000_0055);
    step();
    md(1'b0, 5'd0, 32'd0);
`ifdef WB_BYPASS_EN
    n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, fifo_count_o} !== {1'b1, 5'd4, 32'h0000_0055, 3'd0})
      begin n_fail++; $display("FAIL bypass_direct got we=%0b a=%0d d=%h cnt=%0d", rf_we_o, rf_waddr_o, rf_wdata_o, fifo_count_o); end
    step();
    n_checks++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL bypass_after got we=%0b want 0", rf_we_o); end
`else
    n_checks++; if ({rf_we_o, fifo_count_o} !== {1'b0, 3'd1})
      begin n_fail++; $display("FAIL queued_first got we=%0b cnt=%0d want 0/1", rf_we_o, fifo_count_o); end
    step();
    n_checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, fifo_count_o} !== {1'b1, 5'd4, 32'h0000_0055, 3'd0})
      begin n_fail++; $display("FAIL queued_write got we=%0b a=%0d d=%h cnt=%0d", rf_we_o, rf_waddr_o, rf_wdata_o, fifo_count_o); end
`endif
  endtask

  task automatic test_reset_mid();
    pipe(1'b1, 5'd3, 32'h0000_0033);
    for (int i = 0; i < 3; i++) begin
      md(1'b1, 5'(20 + i), 32'(i));
      step();
    end
    md(1'b0, 5'd0, 32'd0);
    n_checks++; if (fifo_count_o !== 3'd3) begin n_fail++; $display("FAIL mid_queued got cnt=%0d want 3", fifo_count_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({rf_we_o, fifo_count_o, md_ready_o, stall_o} !== {1'b0, 3'd0, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL mid_reset got we=%0b cnt=%0d rdy=%0b stall=%0b want 0/0/1/0", rf_we_o, fifo_count_o, md_ready_o, stall_o); end
    pipe(1'b0, 5'd0, 32'd0);
    step();
    rst = 1'b0;
    step();
    n_checks++; if ({rf_we_o, fifo_count_o} !== {1'b0, 3'd0})
      begin n_fail++; $display("FAIL mid_release got we=%0b cnt=%0d want 0/0", rf_we_o, fifo_count_o); end
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_contention();
    test_full();
    test_waw();
    test_md_r0();
    test_bypass();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
